// File: rtl/sr_pulse_debouncer.sv
// Conditioning stage for an S/R latch: synchronises and debounces two raw buttons
// and turns each accepted press into a fixed-width, mutually exclusive s or r pulse.

module sr_db_channel #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic db,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync_meta_r;
  logic          sync_r;
  logic          db_r;
  logic          rise_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          db_s;
  logic          rise_s;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_r <= 1'b0;
      sync_r      <= 1'b0;
    end else begin
      sync_meta_r <= btn;
      sync_r      <= sync_meta_r;
    end
  end

  // Stability counter: any return to the current level restarts the count.
  always_comb begin
    cnt_s  = cnt_r;
    db_s   = db_r;
    rise_s = 1'b0;
    if (sync_r == db_r) begin
      cnt_s = CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      cnt_s  = CNT_ZERO;
      db_s   = sync_r;
      rise_s = sync_r;
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= CNT_ZERO;
      db_r   <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_s;
      db_r   <= db_s;
      rise_r <= rise_s;
    end
  end

  assign db   = db_r;
  assign rise = rise_r;

endmodule

module sr_pulse_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_WIDTH     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_reset,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict,
  output logic db_set,
  output logic db_reset
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SET  = 2'd1;
  localparam logic [1:0] ST_RST  = 2'd2;

  localparam logic [7:0] PCNT_LAST = 8'(PULSE_WIDTH - 1);

  logic       rise_set_s;
  logic       rise_reset_s;
  logic [1:0] state_r;
  logic [1:0] state_s;
  logic [7:0] pcnt_r;
  logic [7:0] pcnt_s;
  logic       s_r;
  logic       s_s;
  logic       r_r;
  logic       r_s;
  logic       busy_r;
  logic       busy_s;
  logic       conflict_r;
  logic       conflict_s;

  sr_db_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_set_ch (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_set),
    .db   (db_set),
    .rise (rise_set_s)
  );

  sr_db_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_reset_ch (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_reset),
    .db   (db_reset),
    .rise (rise_reset_s)
  );

  // Pulse FSM: outputs are computed here and registered, so s/r/busy track the state.
  always_comb begin
    state_s    = state_r;
    pcnt_s     = pcnt_r;
    s_s        = 1'b0;
    r_s        = 1'b0;
    busy_s     = 1'b0;
    conflict_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rise_set_s && !rise_reset_s) begin
          state_s = ST_SET;
          pcnt_s  = 8'd0;
          s_s     = 1'b1;
          busy_s  = 1'b1;
        end else if (rise_reset_s && !rise_set_s) begin
          state_s = ST_RST;
          pcnt_s  = 8'd0;
          r_s     = 1'b1;
          busy_s  = 1'b1;
        end else if (rise_set_s && rise_reset_s) begin
          conflict_s = 1'b1;
        end else begin
          pcnt_s = 8'd0;
        end
      end
      ST_SET, ST_RST: begin
        // A press landing mid-pulse, including on the final edge, is refused.
        conflict_s = rise_set_s | rise_reset_s;
        if (pcnt_r == PCNT_LAST) begin
          state_s = ST_IDLE;
          pcnt_s  = 8'd0;
        end else begin
          pcnt_s = pcnt_r + 8'd1;
          s_s    = (state_r == ST_SET);
          r_s    = (state_r == ST_RST);
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pcnt_s  = 8'd0;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pcnt_r     <= 8'd0;
      s_r        <= 1'b0;
      r_r        <= 1'b0;
      busy_r     <= 1'b0;
      conflict_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      pcnt_r     <= pcnt_s;
      s_r        <= s_s;
      r_r        <= r_s;
      busy_r     <= busy_s;
      conflict_r <= conflict_s;
    end
  end

  assign s        = s_r;
  assign r        = r_r;
  assign busy     = busy_r;
  assign conflict = conflict_r;

endmodule
